// File: rtl/dircc_mem_pkg.sv
// Shared types and helpers for the DiRCC dual-port processing memory.
// Sweep states, collision counter width and port-2 lane arithmetic.
package dircc_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int COLL_CNT_W = 16;

    function automatic bit ratio_ok(input int ratio);
        return (ratio == 1) || (ratio == 2) || (ratio == 4);
    endfunction

    // Narrow-port sub-word lane; ratio is always a power of two.
    function automatic int lane_idx(input int addr, input int ratio);
        return addr % ratio;
    endfunction

endpackage

// File: rtl/dircc_processing_mem_dp_if.sv
// Avalon-MM slave port bundle with pipelined reads.
// One instance per memory port; widths set per port.
interface dircc_processing_mem_dp_if #(
    parameter int AW = 14,
    parameter int DW = 32,
    parameter int BS = 8
);
    localparam int BW = DW / BS;

    logic [AW-1:0] address;
    logic [BW-1:0] byteenable;
    logic          chipselect;
    logic          write;
    logic          clken;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;

    modport master (
        output address, byteenable, chipselect, write, clken, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, write, clken, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/dircc_mem_read_pipe.sv
// Read-return pipeline: valid/data shift register with a common stall.
// Data registers only load behind a valid so readdata holds between reads.
module dircc_mem_read_pipe #(
    parameter int DW     = 32,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    output logic          o_vld,
    output logic [DW-1:0] o_data
);
    logic          r_vld [STAGES];
    logic [DW-1:0] r_dat [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_dat[s] <= '0;
            end
        end else if (i_adv) begin
            r_vld[0] <= i_vld;
            if (i_vld) r_dat[0] <= i_data;
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
            end
        end
    end

    assign o_vld  = r_vld[STAGES-1];
    assign o_data = r_dat[STAGES-1];
endmodule

// File: rtl/dircc_processing_mem_dp.sv
// DiRCC node processing memory: wide CPU port, narrow mailbox port,
// zero-fill sweep after reset, write-collision counter, range flag.
module dircc_processing_mem_dp
    import dircc_mem_pkg::*;
#(
    parameter int DATA_WIDTH_A   = 32,
    parameter int RATIO          = 2,
    parameter int BYTE_SIZE      = 8,
    parameter int DEPTH_A        = 10240,
    parameter int ADDR_WIDTH_A   = 14,
    parameter int ADDR_WIDTH_B   = 15,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  freeze,
    dircc_processing_mem_dp_if.slave p1,
    dircc_processing_mem_dp_if.slave p2,
    output logic                  init_done,
    output logic [COLL_CNT_W-1:0] collision_count,
    output logic                  range_err
);
    localparam int DW_B   = DATA_WIDTH_A / RATIO;
    localparam int BE_A   = DATA_WIDTH_A / BYTE_SIZE;
    localparam int BE_B   = DW_B / BYTE_SIZE;
    localparam int LW     = $clog2(RATIO);
    localparam int IW     = (DEPTH_A > 1) ? $clog2(DEPTH_A) : 1;
    localparam int STAGES = 1 + OUTPUT_REG;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH_A - 1);
    localparam clr_state_e RST_STATE = clr_state_e'(CLEAR_ON_RESET == 0);

    if (!ratio_ok(RATIO)) begin : g_bad_ratio
        $error("RATIO must be 1, 2 or 4");
    end

    clr_state_e              r_state, w_state_nxt;
    logic [IW-1:0]           r_clr_idx, w_clr_idx_nxt;
    logic                    w_clr_we;
    logic                    r_ready;

    logic [ADDR_WIDTH_B-1:0] w_addr2;
    logic [ADDR_WIDTH_A-1:0] w_word1, w_word2;
    logic [IW-1:0]           w_idx1, w_idx2;
    int                      w_lane2;
    logic                    w_in1, w_in2;
    logic                    w_acc1, w_acc2;
    logic                    w_wr1, w_wr2;
    logic                    w_rd1, w_rd2;
    logic                    w_adv1, w_adv2;
    logic                    w_coll;
    logic [BE_A-1:0]         w_be2;
    logic [DATA_WIDTH_A-1:0] w_wd2;
    logic [DATA_WIDTH_A-1:0] w_row1, w_row2;
    logic [DW_B-1:0]         w_rdat2;
    logic                    w_rdv1, w_rdv2;
    logic [DATA_WIDTH_A-1:0] w_rdd1;
    logic [DW_B-1:0]         w_rdd2;

    logic [DATA_WIDTH_A-1:0] r_mem [DEPTH_A];

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        unique case (r_state)
            CLEAR: begin
                if (!reset_req) begin
                    w_clr_we = 1'b1;
                    if (r_clr_idx == LAST_IDX) w_state_nxt = READY;
                    else w_clr_idx_nxt = r_clr_idx + 1'b1;
                end
            end
            READY: ;
            default: ;
        endcase
    end

    // Ready lags the state by one cycle so the sweep blocks DEPTH_A+1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RST_STATE;
            r_clr_idx <= '0;
            r_ready   <= (CLEAR_ON_RESET == 0);
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_ready   <= (r_state == READY);
        end
    end

    assign w_addr2 = p2.address;
    assign w_word1 = p1.address;
    assign w_word2 = ADDR_WIDTH_A'(w_addr2 >> LW);
    assign w_lane2 = lane_idx(int'(w_addr2), RATIO);
    assign w_idx1  = IW'(w_word1);
    assign w_idx2  = IW'(w_word2);
    assign w_in1   = int'(w_word1) < DEPTH_A;
    assign w_in2   = int'(w_word2) < DEPTH_A;

    assign w_acc1 = p1.chipselect & p1.clken & r_ready & ~reset_req;
    assign w_acc2 = p2.chipselect & p2.clken & r_ready & ~reset_req;
    assign w_wr1  = w_acc1 & p1.write & ~freeze & w_in1;
    assign w_wr2  = w_acc2 & p2.write & ~freeze & w_in2;
    assign w_rd1  = w_acc1 & ~p1.write;
    assign w_rd2  = w_acc2 & ~p2.write;
    assign w_adv1 = p1.clken & ~reset_req;
    assign w_adv2 = p2.clken & ~reset_req;

    always_comb begin
        w_be2 = '0;
        w_wd2 = {RATIO{p2.writedata}};
        w_be2[w_lane2*BE_B +: BE_B] = p2.byteenable;
    end

    // Only byte-level overlap counts; disjoint lanes of one word merge cleanly.
    assign w_coll = w_wr1 & w_wr2 & (w_word1 == w_word2)
                  & (|(p1.byteenable & w_be2));

    // Port 1 is written last so it owns any byte both ports hit.
    always_ff @(posedge clk) begin
        if (w_clr_we) r_mem[r_clr_idx] <= '0;
        for (int b = 0; b < BE_A; b++) begin
            if (w_wr2 && w_be2[b])
                r_mem[w_idx2][b*BYTE_SIZE +: BYTE_SIZE] <=
                    w_wd2[b*BYTE_SIZE +: BYTE_SIZE];
            if (w_wr1 && p1.byteenable[b])
                r_mem[w_idx1][b*BYTE_SIZE +: BYTE_SIZE] <=
                    p1.writedata[b*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    assign w_row1  = w_in1 ? r_mem[w_idx1] : '0;
    assign w_row2  = w_in2 ? r_mem[w_idx2] : '0;
    assign w_rdat2 = w_row2[w_lane2*DW_B +: DW_B];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_count <= '0;
            range_err       <= 1'b0;
        end else begin
            if (w_coll && (collision_count != '1))
                collision_count <= collision_count + 1'b1;
            if ((w_acc1 && !w_in1) || (w_acc2 && !w_in2))
                range_err <= 1'b1;
        end
    end

    dircc_mem_read_pipe #(.DW(DATA_WIDTH_A), .STAGES(STAGES)) u_pipe1 (
        .clk    (clk),
        .rst    (reset),
        .i_adv  (w_adv1),
        .i_vld  (w_rd1),
        .i_data (w_row1),
        .o_vld  (w_rdv1),
        .o_data (w_rdd1)
    );

    dircc_mem_read_pipe #(.DW(DW_B), .STAGES(STAGES)) u_pipe2 (
        .clk    (clk),
        .rst    (reset),
        .i_adv  (w_adv2),
        .i_vld  (w_rd2),
        .i_data (w_rdat2),
        .o_vld  (w_rdv2),
        .o_data (w_rdd2)
    );

    assign p1.readdata      = w_rdd1;
    assign p1.readdatavalid = w_rdv1;
    assign p1.waitrequest   = ~r_ready;
    assign p2.readdata      = w_rdd2;
    assign p2.readdatavalid = w_rdv2;
    assign p2.waitrequest   = ~r_ready;
    assign init_done        = r_ready;
endmodule

// File: tb/tb_dircc_processing_mem_dp.sv
// Bench for dircc_processing_mem_dp: directed vector table, reset/stall
// sequences, and randomized traffic against a byte-addressed model.
module tb_dircc_processing_mem_dp;
    localparam int DEP = 16;

    typedef struct {
        logic        cs1, wr1;
        int          a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        cs2, wr2;
        int          a2;
        logic [1:0]  be2;
        logic [15:0] d2;
        logic        frz;
        logic        v1;
        logic [31:0] e1;
        logic        v2;
        logic [15:0] e2;
        int          ecc;
        logic        ere;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;
    logic freeze = 1'b0;
    logic init0, init1, re0, re1;
    logic [15:0] cc0, cc1;
    int n_chk = 0;
    int n_err = 0;
    int cnt;
    vec_t vt [16];

    logic [7:0]  ref_b [DEP*4];
    logic        mv1, mv2, mre, rcoll, ok1, ok2;
    logic [31:0] md1, rd1;
    logic [15:0] md2, rd2;
    int          mcc, ra1, ra2;
    logic        rc1, rw1, rk1, rc2, rw2, rk2, rfz;
    logic [3:0]  rbe1;
    logic [1:0]  rbe2;

    dircc_processing_mem_dp_if #(.AW(5), .DW(32)) p1_r0();
    dircc_processing_mem_dp_if #(.AW(6), .DW(16)) p2_r0();
    dircc_processing_mem_dp_if #(.AW(5), .DW(32)) p1_r1();
    dircc_processing_mem_dp_if #(.AW(6), .DW(16)) p2_r1();

    dircc_processing_mem_dp #(
        .DATA_WIDTH_A(32), .RATIO(2), .BYTE_SIZE(8), .DEPTH_A(DEP),
        .ADDR_WIDTH_A(5), .ADDR_WIDTH_B(6), .OUTPUT_REG(0),
        .CLEAR_ON_RESET(1)
    ) u0 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .freeze(freeze),
        .p1(p1_r0), .p2(p2_r0), .init_done(init0),
        .collision_count(cc0), .range_err(re0)
    );

    dircc_processing_mem_dp #(
        .DATA_WIDTH_A(32), .RATIO(2), .BYTE_SIZE(8), .DEPTH_A(DEP),
        .ADDR_WIDTH_A(5), .ADDR_WIDTH_B(6), .OUTPUT_REG(1),
        .CLEAR_ON_RESET(1)
    ) u1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .freeze(freeze),
        .p1(p1_r1), .p2(p2_r1), .init_done(init1),
        .collision_count(cc1), .range_err(re1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        p1_r0.chipselect = 0; p1_r0.write = 0; p1_r0.clken = 1;
        p1_r0.address = 0; p1_r0.byteenable = 0; p1_r0.writedata = 0;
        p2_r0.chipselect = 0; p2_r0.write = 0; p2_r0.clken = 1;
        p2_r0.address = 0; p2_r0.byteenable = 0; p2_r0.writedata = 0;
        p1_r1.chipselect = 0; p1_r1.write = 0; p1_r1.clken = 1;
        p1_r1.address = 0; p1_r1.byteenable = 0; p1_r1.writedata = 0;
        p2_r1.chipselect = 0; p2_r1.write = 0; p2_r1.clken = 1;
        p2_r1.address = 0; p2_r1.byteenable = 0; p2_r1.writedata = 0;
        freeze = 0;
    endtask

    task automatic count_wait(output int c);
        c = 0;
        while (p1_r0.waitrequest === 1'b1 && c < 200) begin
            c++;
            tick();
        end
    endtask

    function automatic vec_t mk(
        input logic cs1, wr1, input int a1, input logic [3:0] be1,
        input logic [31:0] d1, input logic cs2, wr2, input int a2,
        input logic [1:0] be2, input logic [15:0] d2, input logic frz,
        input logic v1, input logic [31:0] e1, input logic v2,
        input logic [15:0] e2, input int ecc, input logic ere);
        vec_t v;
        v.cs1 = cs1; v.wr1 = wr1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.cs2 = cs2; v.wr2 = wr2; v.a2 = a2; v.be2 = be2; v.d2 = d2;
        v.frz = frz; v.v1 = v1; v.e1 = e1; v.v2 = v2; v.e2 = e2;
        v.ecc = ecc; v.ere = ere;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(1,1,3,4'hF,32'hDEADBEEF, 0,0,0,0,0,     0, 0,0,0,0,0,0);
        vt[1]  = mk(0,0,0,0,0,           1,0,6,0,0,         0, 0,0,1,16'hBEEF,0,0);
        vt[2]  = mk(0,0,0,0,0,           1,0,7,0,0,         0, 0,0,1,16'hDEAD,0,0);
        vt[3]  = mk(1,1,2,4'h3,32'h11223344, 1,1,5,2'h3,16'hAAAA, 0, 0,0,0,0,0,0);
        vt[4]  = mk(1,0,2,0,0,           0,0,0,0,0,         0, 1,32'hAAAA3344,0,0,0,0);
        vt[5]  = mk(1,1,2,4'h3,32'h11223344, 1,1,4,2'h3,16'hBBBB, 0, 0,0,0,0,1,0);
        vt[6]  = mk(1,0,2,0,0,           0,0,0,0,0,         0, 1,32'hAAAA3344,0,0,1,0);
        vt[7]  = mk(1,1,3,4'hF,32'hCAFEF00D, 1,0,6,0,0,     0, 0,0,1,16'hBEEF,1,0);
        vt[8]  = mk(0,0,0,0,0,           1,0,6,0,0,         0, 0,0,1,16'hF00D,1,0);
        vt[9]  = mk(1,0,3,0,0,           1,1,7,2'h1,16'h1234, 0, 1,32'hCAFEF00D,0,0,1,0);
        vt[10] = mk(1,0,3,0,0,           0,0,0,0,0,         0, 1,32'hCA34F00D,0,0,1,0);
        vt[11] = mk(1,1,1,4'hF,32'h5,    0,0,0,0,0,         1, 0,0,0,0,1,0);
        vt[12] = mk(1,0,1,0,0,           0,0,0,0,0,         0, 1,32'h0,0,0,1,0);
        vt[13] = mk(1,0,3,0,0,           0,0,0,0,0,         0, 1,32'hCA34F00D,0,0,1,0);
        vt[14] = mk(1,0,DEP,0,0,         0,0,0,0,0,         0, 1,32'h0,0,0,1,1);
        vt[15] = mk(0,0,0,0,0,           1,0,2*DEP+1,0,0,   0, 0,0,1,16'h0,1,1);

        idle();
        repeat (2) tick();
        chk("rst_wait1", p1_r0.waitrequest, 1);
        chk("rst_wait2", p2_r0.waitrequest, 1);
        chk("rst_init", init0, 0);
        chk("rst_rdv1", p1_r0.readdatavalid, 0);
        chk("rst_rd1", p1_r0.readdata, 0);
        chk("rst_rd2", p2_r0.readdata, 0);
        chk("rst_cc", cc0, 0);
        chk("rst_re", re0, 0);
        reset = 0;
        count_wait(cnt);
        chk("init_cycles", cnt, DEP + 1);
        chk("init_done", init0, 1);
        chk("init_wait2", p2_r0.waitrequest, 0);
        p1_r0.chipselect = 1; p1_r0.address = 5;
        tick();
        idle();
        chk("init_rd5_v", p1_r0.readdatavalid, 1);
        chk("init_rd5_d", p1_r0.readdata, 0);

        for (int i = 0; i < 16; i++) begin
            p1_r0.chipselect = vt[i].cs1; p1_r0.write = vt[i].wr1;
            p1_r0.address = 5'(vt[i].a1); p1_r0.byteenable = vt[i].be1;
            p1_r0.writedata = vt[i].d1;
            p2_r0.chipselect = vt[i].cs2; p2_r0.write = vt[i].wr2;
            p2_r0.address = 6'(vt[i].a2); p2_r0.byteenable = vt[i].be2;
            p2_r0.writedata = vt[i].d2;
            freeze = vt[i].frz;
            tick();
            chk($sformatf("vec%0d_v1", i), p1_r0.readdatavalid, vt[i].v1);
            chk($sformatf("vec%0d_v2", i), p2_r0.readdatavalid, vt[i].v2);
            if (vt[i].v1) chk($sformatf("vec%0d_d1", i), p1_r0.readdata, vt[i].e1);
            if (vt[i].v2) chk($sformatf("vec%0d_d2", i), p2_r0.readdata, vt[i].e2);
            chk($sformatf("vec%0d_cc", i), cc0, vt[i].ecc);
            chk($sformatf("vec%0d_re", i), re0, vt[i].ere);
        end
        idle();
        tick();

        reset = 1; tick(); reset = 0;
        repeat (8) tick();
        reset = 1; tick();
        chk("rerst_wait", p1_r0.waitrequest, 1);
        chk("rerst_init", init0, 0);
        chk("rerst_cc", cc0, 0);
        chk("rerst_re", re0, 0);
        reset = 0;
        count_wait(cnt);
        chk("rerst_cycles", cnt, DEP + 1);
        p1_r0.chipselect = 1; p1_r0.address = 3;
        p2_r0.chipselect = 1; p2_r0.address = 7;
        tick();
        idle();
        chk("rerst_rd1_v", p1_r0.readdatavalid, 1);
        chk("rerst_rd1_d", p1_r0.readdata, 0);
        chk("rerst_rd2_d", p2_r0.readdata, 0);

        p1_r1.chipselect = 1; p1_r1.write = 1; p1_r1.address = 9;
        p1_r1.byteenable = 4'hF; p1_r1.writedata = 32'h0BADF00D;
        tick();
        p1_r1.write = 0;
        tick();
        chk("oreg_A_v", p1_r1.readdatavalid, 0);
        p1_r1.chipselect = 0; p1_r1.clken = 0;
        tick();
        chk("oreg_B_v", p1_r1.readdatavalid, 0);
        p1_r1.clken = 1;
        tick();
        chk("oreg_C_v", p1_r1.readdatavalid, 1);
        chk("oreg_C_d", p1_r1.readdata, 32'h0BADF00D);
        tick();
        chk("oreg_D_v", p1_r1.readdatavalid, 0);
        p1_r1.chipselect = 1;
        tick();
        p1_r1.chipselect = 0;
        tick();
        chk("rreq_pre_v", p1_r1.readdatavalid, 1);
        reset_req = 1;
        p1_r1.chipselect = 1; p1_r1.write = 1;
        p1_r1.writedata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rreq_hold%0d_v", k), p1_r1.readdatavalid, 1);
            chk($sformatf("rreq_hold%0d_d", k), p1_r1.readdata, 32'h0BADF00D);
        end
        reset_req = 0;
        p1_r1.chipselect = 0; p1_r1.write = 0;
        tick();
        chk("rreq_post_v", p1_r1.readdatavalid, 0);
        p1_r1.chipselect = 1;
        tick();
        p1_r1.chipselect = 0;
        tick();
        chk("rreq_wr_drop_v", p1_r1.readdatavalid, 1);
        chk("rreq_wr_drop_d", p1_r1.readdata, 32'h0BADF00D);
        chk("u1_cc", cc1, 0);
        chk("u1_re", re1, 0);
        chk("u1_init", init1, 1);
        chk("u1_p2_v", p2_r1.readdatavalid, 0);
        idle();
        tick();

        for (int i = 0; i < DEP*4; i++) ref_b[i] = 8'h00;
        mv1 = 0; mv2 = 0; md1 = 0; md2 = 0; mcc = 0; mre = 0;
        for (int it = 0; it < 400; it++) begin
            rc1 = $urandom_range(0, 3) != 0;
            rw1 = $urandom_range(0, 1) == 1;
            rk1 = $urandom_range(0, 7) != 0;
            rc2 = $urandom_range(0, 3) != 0;
            rw2 = $urandom_range(0, 1) == 1;
            rk2 = $urandom_range(0, 7) != 0;
            rfz = $urandom_range(0, 7) == 0;
            ra1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 19)
                                              : $urandom_range(0, 3);
            ra2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 35)
                                              : $urandom_range(0, 7);
            rbe1 = 4'($urandom);
            rbe2 = 2'($urandom);
            rd1 = $urandom;
            rd2 = 16'($urandom);
            p1_r0.chipselect = rc1; p1_r0.write = rw1; p1_r0.clken = rk1;
            p1_r0.address = 5'(ra1); p1_r0.byteenable = rbe1;
            p1_r0.writedata = rd1;
            p2_r0.chipselect = rc2; p2_r0.write = rw2; p2_r0.clken = rk2;
            p2_r0.address = 6'(ra2); p2_r0.byteenable = rbe2;
            p2_r0.writedata = rd2;
            freeze = rfz;

            if (rk1) begin
                mv1 = rc1 && !rw1;
                if (mv1)
                    md1 = (ra1 < DEP) ? {ref_b[ra1*4+3], ref_b[ra1*4+2],
                                         ref_b[ra1*4+1], ref_b[ra1*4]} : 32'h0;
            end
            if (rk2) begin
                mv2 = rc2 && !rw2;
                if (mv2)
                    md2 = (ra2 < 2*DEP) ? {ref_b[ra2*2+1], ref_b[ra2*2]} : 16'h0;
            end
            if ((rc1 && rk1 && ra1 >= DEP) || (rc2 && rk2 && ra2 >= 2*DEP))
                mre = 1;
            ok1 = rc1 && rk1 && rw1 && !rfz && (ra1 < DEP);
            ok2 = rc2 && rk2 && rw2 && !rfz && (ra2 < 2*DEP);
            rcoll = 0;
            if (ok1 && ok2)
                for (int j = 0; j < 4; j++)
                    for (int k = 0; k < 2; k++)
                        if (rbe1[j] && rbe2[k] && (ra1*4 + j == ra2*2 + k))
                            rcoll = 1;
            if (rcoll && mcc < 65535) mcc++;
            if (ok2)
                for (int k = 0; k < 2; k++)
                    if (rbe2[k]) ref_b[ra2*2+k] = rd2[k*8 +: 8];
            if (ok1)
                for (int j = 0; j < 4; j++)
                    if (rbe1[j]) ref_b[ra1*4+j] = rd1[j*8 +: 8];

            tick();
            chk("rnd_v1", p1_r0.readdatavalid, mv1);
            chk("rnd_d1", p1_r0.readdata, md1);
            chk("rnd_v2", p2_r0.readdatavalid, mv2);
            chk("rnd_d2", p2_r0.readdata, md2);
            chk("rnd_cc", cc0, mcc);
            chk("rnd_re", re0, mre);
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
